// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one synchronous data RAM among NUM_CORES cores.
// Each granted transaction runs IDLE -> ACCESS -> DONE and ends with a one-cycle memAV pulse.
module mem_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_CORES = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [NUM_CORES-1:0]       memREAD,
    input  logic [NUM_CORES-1:0]       memWRITE,
    input  logic [NUM_CORES*WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]       memAV,
    output logic [WIDTH-1:0]           DRAM_dataIn,
    output logic [WIDTH-1:0]           ram_addr,
    output logic [WIDTH-1:0]           ram_wdata,
    output logic                       ram_we,
    output logic                       ram_re,
    input  logic [WIDTH-1:0]           ram_rdata,
    output logic [2:0]                 grant_id,
    output logic                       busy,
    output logic [1:0]                 fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Handshake: a core raises memREAD/memWRITE (valid) and holds it, with address and
    // data, until its memAV pulse (ready/complete); it drops the request in that cycle.
    logic [1:0]           state;
    logic [2:0]           last_grant;
    logic                 op_write;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] win_mask;
    logic [2:0]           winner;
    logic                 found;
    logic                 in_access;

    assign eligible  = (memREAD | memWRITE) & ~memAV;
    assign fsm_state = state;
    assign busy      = (state != IDLE);
    assign in_access = (state == ACCESS);

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = last_grant;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(last_grant) + k) % NUM_CORES;
            if (!found && |(eligible & (NUM_CORES'(1) << idx))) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    assign win_mask = NUM_CORES'(1) << winner;

    // RAM port is driven only while ACCESS; the strobe follows the latched operation.
    always_comb begin
        ram_we    = in_access && op_write;
        ram_re    = in_access && !op_write;
        ram_addr  = '0;
        ram_wdata = '0;
        if (in_access) begin
            ram_addr  = WIDTH'(core_addr  >> (int'(grant_id) * WIDTH));
            ram_wdata = WIDTH'(core_wdata >> (int'(grant_id) * WIDTH));
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            memAV       <= '0;
            DRAM_dataIn <= '0;
            grant_id    <= '0;
            last_grant  <= 3'(NUM_CORES - 1);
            op_write    <= 1'b0;
        end else begin
            memAV <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= ACCESS;
                        grant_id   <= winner;
                        last_grant <= winner;
                        op_write   <= |(memWRITE & win_mask);
                    end
                end
                ACCESS: state <= DONE;
                DONE: begin
                    state <= IDLE;
                    memAV <= NUM_CORES'(1) << grant_id;
                    if (!op_write) DRAM_dataIn <= ram_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: core agents, a behavioural RAM, and a
// transaction-timed reference model of grant order, RAM strobes and completions.
module tb_mem_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic [N-1:0]     memREAD, memWRITE;
    logic [N*W-1:0]   core_addr, core_wdata;
    logic [N-1:0]     memAV;
    logic [W-1:0]     DRAM_dataIn, ram_addr, ram_wdata;
    logic             ram_we, ram_re;
    logic [W-1:0]     ram_rdata = '0;
    logic [2:0]       grant_id;
    logic             busy;
    logic [1:0]       fsm_state;

    always #5 Clk = ~Clk;

    mem_arbiter #(.WIDTH(W), .NUM_CORES(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .memREAD(memREAD), .memWRITE(memWRITE),
        .core_addr(core_addr), .core_wdata(core_wdata), .memAV(memAV),
        .DRAM_dataIn(DRAM_dataIn), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .grant_id(grant_id), .busy(busy), .fsm_state(fsm_state)
    );

    // Synchronous RAM with one-cycle read latency.
    logic [W-1:0] ram [256];
    always @(posedge Clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Core agents
    logic [N-1:0] rd = '0, wr = '0, pending = '0, granted = '0;
    logic [W-1:0] a [N];
    logic [W-1:0] d [N];
    logic [N-1:0] core_en = '0;
    int p_new = 0;
    int p_drop = 0;

    // Reference model
    logic [W-1:0] ref_mem [256];
    bit           m_act = 0;
    int           m_g = 0, m_win = 0, m_last = N - 1;
    bit           m_wr = 0;
    logic [W-1:0] m_addr = '0, m_data = '0;
    logic [2:0]   exp_gid = '0;
    logic [W-1:0] exp_dout = '0;
    logic [N-1:0] cur_av = '0;
    int           grant_log[$];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            memREAD[i]              = rd[i];
            memWRITE[i]             = wr[i];
            core_addr[i*W +: W]     = a[i];
            core_wdata[i*W +: W]    = d[i];
        end
    endtask

    task automatic arb();
        logic [N-1:0] el;
        el = (rd | wr) & ~cur_av;
        if (m_act || el == '0) return;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (el[idx]) begin
                m_act = 1; m_g = cyc; m_win = idx; m_wr = wr[idx];
                m_addr = a[idx]; m_data = d[idx];
                granted[idx] = 1'b1; m_last = idx;
                grant_log.push_back(idx);
                break;
            end
        end
    endtask

    task automatic step();
        bit in_access, in_done;
        @(posedge Clk); #1; cyc++;
        cur_av = '0;
        in_access = m_act && (cyc == m_g + 1);
        in_done   = m_act && (cyc == m_g + 2);
        if (in_access) exp_gid = 3'(m_win);
        if (m_act && cyc == m_g + 3) begin
            cur_av = N'(1) << m_win;
            if (!m_wr) exp_dout = ref_mem[m_addr];
            m_act = 0;
            granted[m_win] = 1'b0;
        end
        check_eq("ram_we", ram_we, in_access && m_wr);
        check_eq("ram_re", ram_re, in_access && !m_wr);
        check_eq("ram_addr", ram_addr, in_access ? m_addr : '0);
        check_eq("ram_wdata", ram_wdata, in_access ? m_data : '0);
        check_eq("busy", busy, in_access || in_done);
        check_eq("memAV", memAV, cur_av);
        check_eq("dout", DRAM_dataIn, exp_dout);
        check_eq("grant_id", grant_id, exp_gid);
        if (in_access && m_wr) ref_mem[m_addr] = m_data;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && cur_av[i]) begin
                pending[i] = 0; rd[i] = 0; wr[i] = 0;
            end else if (pending[i] && !granted[i] && $urandom_range(0, 99) < p_drop) begin
                pending[i] = 0; rd[i] = 0; wr[i] = 0;
            end else if (!pending[i] && !cur_av[i] && core_en[i] && $urandom_range(0, 99) < p_new) begin
                int op;
                op = $urandom_range(0, 3);
                pending[i] = 1;
                rd[i] = (op != 2);
                wr[i] = (op >= 2);
                a[i] = W'($urandom_range(0, 255));
                d[i] = W'($urandom_range(0, 255));
            end
        end
        arb();
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int i, input bit r, input bit w, input logic [W-1:0] ad, input logic [W-1:0] dt);
        pending[i] = 1; rd[i] = r; wr[i] = w; a[i] = ad; d[i] = dt;
        arb();
        drive();
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0;
        m_act = 0; m_last = N - 1; exp_gid = '0; exp_dout = '0; cur_av = '0;
        rd = '0; wr = '0; pending = '0; granted = '0;
        core_en = '0; p_new = 0; p_drop = 0;
        drive();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = W'($urandom_range(0, 255));
            ref_mem[i] = ram[i];
        end
        ram[8'h10] = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        apply_reset();

        check_eq("rst_memAV", memAV, 0);
        check_eq("rst_dout", DRAM_dataIn, 0);
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_re", ram_re, 0);
        check_eq("rst_addr", ram_addr, 0);
        check_eq("rst_wdata", ram_wdata, 0);
        check_eq("rst_gid", grant_id, 0);
        check_eq("rst_busy", busy, 0);

        // All four cores read together right after reset
        for (int i = 0; i < N; i++) begin
            pending[i] = 1; rd[i] = 1; wr[i] = 0;
            a[i] = W'(8'h40 + i); d[i] = '0;
        end
        arb();
        drive();
        run(16);
        check_eq("order_len", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check_eq("order", grant_log[k], k);

        // Core 2 reads 0x10 holding 0x5A
        issue(2, 1, 0, 8'h10, 8'h00);
        step();
        check_eq("rd_strobe", ram_re, 1);
        check_eq("rd_addr", ram_addr, 8'h10);
        run(2);
        check_eq("rd_av", memAV, 4'b0100);
        check_eq("rd_data", DRAM_dataIn, 8'h5A);
        run(2);

        // Core 1 writes 0x33 to 0x20; read data register must hold
        issue(1, 0, 1, 8'h20, 8'h33);
        step();
        check_eq("wr_strobe", ram_we, 1);
        check_eq("wr_addr", ram_addr, 8'h20);
        check_eq("wr_data", ram_wdata, 8'h33);
        run(2);
        check_eq("wr_av", memAV, 4'b0010);
        check_eq("wr_dout_hold", DRAM_dataIn, 8'h5A);
        run(2);

        // Read and write together: write wins
        issue(0, 1, 1, 8'h30, 8'h77);
        step();
        check_eq("both_we", ram_we, 1);
        check_eq("both_re", ram_re, 0);
        run(4);

        // Random traffic with occasional dropped requests
        core_en = '1; p_new = 30; p_drop = 5;
        run(1500);
        core_en = '0; p_drop = 0;
        run(20);

        // Cores 0 and 3 request continuously
        grant_log.delete();
        core_en = 4'b1001; p_new = 100;
        run(40);
        core_en = '0;
        run(10);
        check_eq("alt_count", grant_log.size() >= 10, 1);
        for (int k = 0; k < grant_log.size(); k++) begin
            check_eq("alt_core", grant_log[k] == 0 || grant_log[k] == 3, 1);
            if (k > 0) check_eq("alt_repeat", grant_log[k] == grant_log[k-1], 0);
        end

        // Reset asserted during ACCESS
        begin
            bit hit;
            hit = 0;
            issue(1, 1, 0, 8'h55, 8'h00);
            for (int i = 0; i < 20 && !hit; i++) begin
                step();
                hit = m_act && (cyc == m_g + 1);
            end
            check_eq("reached_access", hit, 1);
            #2;
            Rst_n = 1'b0;
            #1;
            check_eq("abort_re", ram_re, 0);
            check_eq("abort_we", ram_we, 0);
            check_eq("abort_busy", busy, 0);
            apply_reset();
            run(6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data and address width of each core port and of the shared RAM port.
REQ-002 Parameter NUM_CORES, default 4, range 2..8, number of cores sharing one data RAM.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  reset; asynchronous and active-low.
REQ-005 memREAD  input  NUM_CORES  per-core read request; bit i belongs to core i.
REQ-006 memWRITE  input  NUM_CORES  per-core write request; bit i belongs to core i.
REQ-007 core_addr  input  NUM_CORES*WIDTH  packed DRAM_addr of all cores; core i uses bits [i*WIDTH +: WIDTH].
REQ-008 core_wdata  input  NUM_CORES*WIDTH  packed DRAM_dataOut of all cores; same packing as core_addr.
REQ-009 memAV  output  NUM_CORES  per-core one-cycle completion pulse, registered.
REQ-010 DRAM_dataIn  output  WIDTH  read data broadcast to all cores, registered; valid only while memAV of the requesting core is high.
REQ-011 ram_addr  output  WIDTH  address to the shared RAM.
REQ-012 ram_wdata  output  WIDTH  write data to the shared RAM.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_re  output  1  RAM read strobe.
REQ-015 ram_rdata  input  WIDTH  RAM read data; valid on the cycle after ram_re (synchronous RAM, 1-cycle latency).
REQ-016 grant_id  output  3  index of the currently or most recently granted core.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 Request protocol: a core holds its request (memREAD or memWRITE), its address and its write data stable until its memAV pulse, and deasserts the request in the cycle memAV is high.
REQ-019 The FSM has three states, IDLE, ACCESS and DONE, with transitions IDLE->ACCESS (any eligible request), ACCESS->DONE (always) and DONE->IDLE (always).
REQ-020 Eligible requests in IDLE are (memREAD|memWRITE) masked by the current memAV, so a core whose memAV is high in a cycle is ignored in that cycle.
REQ-021 Arbitration is round-robin: in IDLE, the winner is the first eligible core searching upward from last_grant+1, modulo NUM_CORES.
REQ-022 On the IDLE->ACCESS edge, the arbiter latches the winner into grant_id and last_grant, and latches the operation type; memWRITE takes priority if both memREAD and memWRITE are set.
REQ-023 During ACCESS only, ram_addr and ram_wdata equal the granted core's core_addr and core_wdata, and exactly one of ram_we or ram_re is 1.
REQ-024 Outside ACCESS, ram_we and ram_re are 0, and ram_addr and ram_wdata hold 0.
REQ-025 On the DONE->IDLE edge, memAV[grant_id] is registered to 1 for exactly one cycle; for a read, DRAM_dataIn is registered from ram_rdata at the same edge.
REQ-026 For a write, DRAM_dataIn keeps its previous value.
REQ-027 Latency: with a request first visible in IDLE at cycle N, ram strobe is high at N+1 and memAV is high at N+3.
REQ-028 Throughput: at most one transaction per 3 cycles; a new grant may occur in the same cycle that memAV pulses, to a different core.
REQ-029 A request that drops before it is granted is lost with no side effects.
REQ-030 Request, address or data changes after the grant are ignored; the transaction completes using the values sampled in ACCESS.
REQ-031 Bits of memREAD and memWRITE at index >= NUM_CORES do not exist; grant_id never exceeds NUM_CORES-1.

Reset
REQ-032 While Rst_n is 0, the arbiter asynchronously sets state=IDLE, memAV=0, DRAM_dataIn=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, grant_id=0, busy=0, and last_grant=NUM_CORES-1, so that core 0 wins first after reset.
REQ-033 Reset asserted mid-transaction aborts the transaction immediately; no memAV pulse is produced for the aborted transaction, and the core re-requests under REQ-018.

Verification
REQ-034 Core 2 reads addr 0x10, RAM[0x10]=0x5A -> ram_re=1 with ram_addr=0x10 at N+1; memAV=4'b0100 and DRAM_dataIn=0x5A at N+3.
REQ-035 Core 1 writes 0x33 to 0x20 -> one cycle of ram_we=1, ram_addr=0x20, ram_wdata=0x33; memAV=4'b0010; DRAM_dataIn unchanged.
REQ-036 All 4 cores request a read together right after reset -> grants in order 0,1,2,3, memAV pulses 3 cycles apart, each with the correct data.
REQ-037 Cores 0 and 3 request continuously -> grants alternate 0,3,0,3; neither core is granted twice in a row.
REQ-038 Core 0 sets memREAD and memWRITE together -> only ram_we pulses.
REQ-039 Rst_n driven low during ACCESS -> ram_we, ram_re and busy go to 0 at once with no clock edge; no memAV follows.
